// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the ALU core and its shifter.
// Pure declarations; no logic, no latency, no flow control.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_PASB = 4'b0110;
    localparam logic [3:0] OP_PASA = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLR  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter/rotator for SLL, SLR, SRL, SRA with carry-out of the last bit moved.
// Purely combinational; no flow control.
module alu_shifter (
    input  logic [15:0] a,
    input  logic [3:0]  amt,
    input  logic [3:0]  op,
    output logic [15:0] y,
    output logic        c
);
    import alu_pkg::*;

    logic [16:0]        shl;
    logic [16:0]        shr;
    logic signed [16:0] ext;
    logic [16:0]        sra;
    logic [31:0]        rot;

    // The extra bit on each side catches the last bit shifted out; it is 0 when amt is 0.
    assign shl = {1'b0, a} << amt;
    assign shr = {a, 1'b0} >> amt;
    assign ext = {a, 1'b0};
    assign sra = ext >>> amt;
    assign rot = {a, a} << amt;

    always_comb begin
        y = a;
        c = 1'b0;
        case (op)
            OP_SLL: begin
                y = shl[15:0];
                c = shl[16];
            end
            OP_SLR: begin
                y = rot[31:16];
                c = (amt != 4'd0) && rot[16];
            end
            OP_SRL: begin
                y = shr[16:1];
                c = shr[0];
            end
            OP_SRA: begin
                y = sra[16:1];
                c = sra[0];
            end
            default: begin
                y = a;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// 16-bit ALU: arithmetic, logic, pass and shift ops with {S,Z,C,V} flags.
// One-cycle latency, result and flags registered every edge; no handshake.
module alu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  salu,
    output logic [15:0] aout,
    output logic [3:0]  fout
);
    import alu_pkg::*;

    logic [16:0] sum;
    logic [16:0] diff;
    logic [15:0] sh_y;
    logic        sh_c;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        known;
    logic [3:0]  flags_nxt;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    alu_shifter u_shifter (
        .a   (a),
        .amt (b[3:0]),
        .op  (salu),
        .y   (sh_y),
        .c   (sh_c)
    );

    always_comb begin
        res   = 16'h0000;
        c     = 1'b0;
        v     = 1'b0;
        known = 1'b1;
        case (salu)
            OP_ADD: begin
                res = sum[15:0];
                c   = sum[16];
                v   = (a[15] == b[15]) && (sum[15] != a[15]);
            end
            OP_SUB: begin
                res = diff[15:0];
                c   = diff[16];
                v   = (a[15] != b[15]) && (diff[15] != a[15]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_PASB: res = b;
            OP_PASA: res = a;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                res = sh_y;
                c   = sh_c;
            end
            default: known = 1'b0;
        endcase
    end

    // Undefined opcodes report all-zero flags, including Z.
    always_comb begin
        flags_nxt = 4'b0000;
        if (known) begin
            flags_nxt[FLAG_S] = res[15];
            flags_nxt[FLAG_Z] = (res == 16'h0000);
            flags_nxt[FLAG_C] = c;
            flags_nxt[FLAG_V] = v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aout <= 16'h0000;
            fout <= 4'b0000;
        end else begin
            aout <= res;
            fout <= flags_nxt;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboarded random and directed test of alu_core against an arithmetic reference model.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  salu;
    logic [15:0] aout;
    logic [3:0]  fout;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] ea;
        logic [3:0]  ef;
        string       name;
    } exp_t;

    exp_t q[$];

    alu_core dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .salu (salu),
        .aout (aout),
        .fout (fout)
    );

    always #5 clk = ~clk;

    function automatic int to_signed(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference: plain integer arithmetic and bit-at-a-time shifting.
    function automatic void model(input int op, input int x, input int y,
                                  output int r, output int f);
        int s, z, cy, ov, n, t, sr;
        cy = 0; ov = 0; r = 0;
        n  = y % 16;
        t  = x;
        case (op)
            0: begin
                r  = (x + y) % 65536;
                cy = (x + y > 65535) ? 1 : 0;
                sr = to_signed(x) + to_signed(y);
                ov = (sr > 32767 || sr < -32768) ? 1 : 0;
            end
            1: begin
                r  = (x - y + 65536) % 65536;
                cy = (x < y) ? 1 : 0;
                sr = to_signed(x) - to_signed(y);
                ov = (sr > 32767 || sr < -32768) ? 1 : 0;
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 65535 - x;
            6: r = y;
            7: r = x;
            8: begin
                for (int i = 0; i < n; i++) begin cy = (t / 32768) % 2; t = (t * 2) % 65536; end
                r = t;
            end
            9: begin
                for (int i = 0; i < n; i++) begin cy = (t / 32768) % 2; t = (t * 2) % 65536 + cy; end
                r = t;
            end
            10: begin
                for (int i = 0; i < n; i++) begin cy = t % 2; t = t / 2; end
                r = t;
            end
            11: begin
                for (int i = 0; i < n; i++) begin cy = t % 2; t = t / 2 + ((t >= 32768) ? 32768 : 0); end
                r = t;
            end
            default: begin r = 0; f = 0; return; end
        endcase
        s = (r >= 32768) ? 1 : 0;
        z = (r == 0) ? 1 : 0;
        f = s * 8 + z * 4 + cy * 2 + ov;
    endfunction

    // Drive on the falling edge; the DUT captures at the next rising edge.
    task automatic issue(input logic r, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] op, input logic [15:0] ea, input logic [3:0] ef,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst  = r;
        a    = x;
        b    = y;
        salu = op;
        e.ea = ea; e.ef = ef; e.name = name;
        q.push_back(e);
    endtask

    task automatic issue_model(input logic r, input logic [15:0] x, input logic [15:0] y,
                               input logic [3:0] op, input string name);
        int mr, mf;
        model(int'(op), int'(x), int'(y), mr, mf);
        if (r) begin mr = 0; mf = 0; end
        issue(r, x, y, op, mr[15:0], mf[3:0], name);
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'h8000;
            3: v = 16'h7FFF;
            default: v = 16'($urandom_range(0, 65535));
        endcase
        return v;
    endfunction

    // Monitor: every rising edge presents exactly one result for the oldest pending vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (aout !== e.ea || fout !== e.ef) begin
                    miscompares++;
                    $display("FAIL %s: aout=%h fout=%b, required aout=%h fout=%b",
                             e.name, aout, fout, e.ea, e.ef);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; a = 16'h0; b = 16'h0; salu = 4'h0;

        issue(1'b1, 16'h1234, 16'h0001, 4'b0000, 16'h0000, 4'b0000, "reset_state");
        issue(1'b0, 16'd5,     16'd8,     4'b0001, 16'hFFFD, 4'b1010, "sub_5_8");
        issue(1'b0, 16'd20000, 16'd20000, 4'b0001, 16'h0000, 4'b0100, "sub_equal");
        issue(1'b0, 16'd30000, 16'd40000, 4'b0001, 16'hD8F0, 4'b1011, "sub_ovf_pos_neg");
        issue(1'b0, 16'd40000, 16'd30000, 4'b0001, 16'd10000, 4'b0001, "sub_ovf_neg_pos");
        issue(1'b0, 16'hFF00, 16'd4, 4'b1000, 16'hF000, 4'b1010, "sll_ff00_4");
        issue(1'b0, 16'hFF00, 16'd4, 4'b1001, 16'hF00F, 4'b1010, "slr_ff00_4");
        issue(1'b0, 16'hFF00, 16'd4, 4'b1010, 16'h0FF0, 4'b0000, "srl_ff00_4");
        issue(1'b0, 16'hFF00, 16'd4, 4'b1011, 16'hFFF0, 4'b1000, "sra_ff00_4");
        issue(1'b0, 16'h00FF, 16'd4,      4'b1011, 16'h000F, 4'b0010, "sra_00ff_4");
        issue(1'b0, 16'h00FF, 16'd10,     4'b1011, 16'h0000, 4'b0100, "sra_00ff_10");
        issue(1'b0, 16'h00FF, 16'h0014,   4'b1011, 16'h000F, 4'b0010, "sra_amt_upper_ignored");
        issue(1'b0, 16'h8001, 16'h0010,   4'b1000, 16'h8001, 4'b1000, "sll_amt_zero");
        issue(1'b0, 16'hFFFF, 16'h0001,   4'b0000, 16'h0000, 4'b0110, "add_carry");
        issue(1'b0, 16'h7FFF, 16'h0001,   4'b0000, 16'h8000, 4'b1001, "add_ovf");
        issue(1'b0, 16'h00FF, 16'h1234,   4'b0101, 16'hFF00, 4'b1000, "not_a");
        issue(1'b0, 16'h0001, 16'h0002,   4'b1100, 16'h0000, 4'b0000, "undef_op");
        issue(1'b0, 16'h0001, 16'h0002,   4'b0000, 16'h0003, 4'b0000, "add_before_rst");
        issue(1'b1, 16'h0001, 16'h0002,   4'b0000, 16'h0000, 4'b0000, "rst_mid_stream");
        issue(1'b0, 16'h0001, 16'h0002,   4'b0000, 16'h0003, 4'b0000, "resume_after_rst");

        for (int i = 0; i < 3000; i++) begin
            issue_model(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                        pick16(), pick16(), 4'($urandom_range(0, 15)), "random");
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port a, input, 16 bits: first operand; the value shifted or rotated for shift ops.
REQ-004 SHALL have port b, input, 16 bits: second operand; its bits [3:0] give the shift or rotate amount for shift ops.
REQ-005 SHALL have port salu, input, 4 bits: operation select.
REQ-006 SHALL have port aout, output, 16 bits: registered result.
REQ-007 SHALL have port fout, output, 4 bits: registered flags {S,Z,C,V}, with fout[3]=S, [2]=Z, [1]=C, [0]=V.

Function
REQ-008 SHALL decode salu as: 0000 ADD a+b; 0001 SUB a-b; 0010 AND; 0011 OR; 0100 XOR; 0101 NOT a; 0110 pass b; 0111 pass a.
REQ-009 SHALL further decode salu as: 1000 SLL (a shifted left logical); 1001 SLR (a rotated left); 1010 SRL (a shifted right logical); 1011 SRA (a shifted right arithmetic); 1100-1111 result 0 with all flags 0.
REQ-010 SHALL compute the result combinationally and register aout and fout on every rising clk edge, giving 1-cycle latency with no enable or handshake.
REQ-011 SHALL perform arithmetic modulo 2^16, treating operands as unsigned for C and as two's complement for V.
REQ-012 SHALL set S = result[15] and Z = (result == 0) for every defined opcode.
REQ-013 SHALL set, for ADD, C = carry out of bit 15 and V = signed overflow.
REQ-014 SHALL set, for SUB, C = borrow (a < b unsigned) and V = signed overflow (operand signs differ and result sign differs from a).
REQ-015 SHALL use shift amount n = b[3:0] and ignore b[15:4]; n = 0 leaves a unchanged with C = 0.
REQ-016 SHALL set, for SLL, C = a[16-n]; for SRL and SRA, C = a[n-1]; for SLR, C = the bit rotated into result[0]; when n = 0, C = 0 in every shift op.
REQ-017 SHALL fill SRA vacated bits with a[15].
REQ-018 SHALL set V = 0 for all logic, pass, shift and rotate ops, and C = 0 for logic and pass ops.

Reset
REQ-019 SHALL load aout = 16'h0000 and fout = 4'b0000 on any clk edge with rst = 1, overriding the computed result.
REQ-020 SHALL register the operation presented on the first edge after rst deasserts normally, with no warm-up cycles.

Structure
REQ-021 SHALL place opcode constants (ADD..SRA) and flag bit-index constants in a shared package, alu_pkg.
REQ-022 SHALL contain one sub-module, alu_shifter (combinational barrel shifter/rotator covering SLL, SLR, SRL, SRA, with carry-out); the arithmetic, logic, flag logic and output register stay in alu_core.

Verification
REQ-023 SHALL verify SUB: a=5, b=8 -> aout=0xFFFD (65533), fout=1010; a=20000, b=20000 -> aout=0, fout=0100.
REQ-024 SHALL verify SUB overflow: a=30000, b=40000 -> aout=0xD8F0, fout=1011; a=40000, b=30000 -> aout=10000, fout=0001.
REQ-025 SHALL verify a=0xFF00, b=4: SLL -> 0xF000, C=1; SLR -> 0xF00F; SRL -> 0x0FF0, C=0; SRA -> 0xFFF0.
REQ-026 SHALL verify SRA with a=0x00FF: b=4 -> 0x000F, C=1; b=10 -> 0x0000, Z=1; and b=0x0014 shifts by 4.
REQ-027 SHALL verify latency and reset: aout changes exactly one edge after inputs change; rst=1 mid-stream -> aout=0, fout=0 at the next edge; operation resumes on the first edge after rst releases.
